// File: rtl/vga_pkg.sv
// Shared definitions for the VGA adaptor family: fill-engine states and
// per-resolution memory geometry so coordinate widths agree across blocks.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } fill_state_e;

    localparam int COLOR_DEPTH_DEF = 3;

    // "160x120"
    localparam int COLS_160X120 = 160;
    localparam int ROWS_160X120 = 120;
    localparam int NX_160X120   = 8;
    localparam int NY_160X120   = 7;

    // "320x240"
    localparam int COLS_320X240 = 320;
    localparam int ROWS_320X240 = 240;
    localparam int NX_320X240   = 9;
    localparam int NY_320X240   = 8;

    // "640x480"
    localparam int COLS_640X480 = 640;
    localparam int ROWS_640X480 = 480;
    localparam int NX_640X480   = 10;
    localparam int NY_640X480   = 9;

endpackage

// File: rtl/vga_rect_clip.sv
// Clips a fill rectangle against the video memory bounds. Purely
// combinational; the parent registers the result during SETUP.
module vga_rect_clip import vga_pkg::*; #(
    parameter int nX   = NX_160X120,
    parameter int nY   = NY_160X120,
    parameter int COLS = COLS_160X120,
    parameter int ROWS = ROWS_160X120
) (
    input  logic [nX-1:0] x0_i,
    input  logic [nY-1:0] y0_i,
    input  logic [nX:0]   w_i,
    input  logic [nY:0]   h_i,
    output logic [nX:0]   x_end_o,
    output logic [nY:0]   y_end_o,
    output logic          empty_o
);

    // One extra bit on the sums so x0+w and y0+h can never wrap before the min.
    logic [nX+1:0] x_sum;
    logic [nY+1:0] y_sum;

    assign x_sum = (nX+2)'(x0_i) + (nX+2)'(w_i);
    assign y_sum = (nY+2)'(y0_i) + (nY+2)'(h_i);

    assign x_end_o = (x_sum > (nX+2)'(COLS)) ? (nX+1)'(COLS) : x_sum[nX:0];
    assign y_end_o = (y_sum > (nY+2)'(ROWS)) ? (nY+1)'(ROWS) : y_sum[nY:0];

    assign empty_o = (w_i == '0) || (h_i == '0) ||
                     ((nX+1)'(x0_i) >= (nX+1)'(COLS)) ||
                     ((nY+1)'(y0_i) >= (nY+1)'(ROWS));

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: accepts one command, clips it to video memory,
// then emits one (x, y, colour) plot per accepted write in raster order.
//
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   SETUP | latch clipped extents, decide fill vs. empty
//   FILL  | plot held high, advance on each accepted write
//   DONE  | one-cycle done pulse, then back to IDLE
module vga_rect_fill import vga_pkg::*; #(
    parameter int COLOR_DEPTH = COLOR_DEPTH_DEF,
    parameter int nX          = NX_160X120,
    parameter int nY          = NY_160X120,
    parameter int COLS        = COLS_160X120,
    parameter int ROWS        = ROWS_160X120
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [nX-1:0]          cmd_x0,
    input  logic [nY-1:0]          cmd_y0,
    input  logic [nX:0]            cmd_w,
    input  logic [nY:0]            cmd_h,
    input  logic [COLOR_DEPTH-1:0] cmd_color,
    output logic [nX-1:0]          x,
    output logic [nY-1:0]          y,
    output logic [COLOR_DEPTH-1:0] colour,
    output logic                   plot,
    input  logic                   plot_ready,
    output logic                   busy,
    output logic                   done
);

    fill_state_e state_q, state_d;

    logic [nX-1:0]          x0_q, x0_d;
    logic [nY-1:0]          y0_q, y0_d;
    logic [nX:0]            w_q, w_d;
    logic [nY:0]            h_q, h_d;
    logic [COLOR_DEPTH-1:0] col_q, col_d;
    logic [nX:0]            x_end_q, x_end_d;
    logic [nY:0]            y_end_q, y_end_d;
    logic [nX-1:0]          x_q, x_d;
    logic [nY-1:0]          y_q, y_d;
    logic [COLOR_DEPTH-1:0] colour_q, colour_d;
    logic                   plot_q, plot_d;
    logic                   done_q, done_d;

    logic [nX:0] clip_x_end;
    logic [nY:0] clip_y_end;
    logic        clip_empty;
    logic [nX:0] x_inc;
    logic [nY:0] y_inc;

    vga_rect_clip #(
        .nX   (nX),
        .nY   (nY),
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_clip (
        .x0_i    (x0_q),
        .y0_i    (y0_q),
        .w_i     (w_q),
        .h_i     (h_q),
        .x_end_o (clip_x_end),
        .y_end_o (clip_y_end),
        .empty_o (clip_empty)
    );

    assign x_inc = {1'b0, x_q} + (nX+1)'(1);
    assign y_inc = {1'b0, y_q} + (nY+1)'(1);

    // Next-state and registered-output logic for the fill sequencer.
    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        col_d    = col_q;
        x_end_d  = x_end_q;
        y_end_d  = y_end_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = plot_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = SETUP;
                    x0_d    = cmd_x0;
                    y0_d    = cmd_y0;
                    w_d     = cmd_w;
                    h_d     = cmd_h;
                    col_d   = cmd_color;
                end
            end
            SETUP: begin
                x_end_d = clip_x_end;
                y_end_d = clip_y_end;
                if (clip_empty) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d  = FILL;
                    x_d      = x0_q;
                    y_d      = y0_q;
                    colour_d = col_q;
                    plot_d   = 1'b1;
                end
            end
            FILL: begin
                // Position only moves on an accepted write, so a stall holds it.
                if (plot_q && plot_ready) begin
                    if (x_inc == x_end_q) begin
                        if (y_inc == y_end_q) begin
                            state_d = DONE;
                            plot_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            x_d = x0_q;
                            y_d = y_inc[nY-1:0];
                        end
                    end else begin
                        x_d = x_inc[nX-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            col_q    <= '0;
            x_end_q  <= '0;
            y_end_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            col_q    <= col_d;
            x_end_q  <= x_end_d;
            y_end_q  <= y_end_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Scoreboard bench for vga_rect_fill: the driver pushes expected pixels per
// command, a negedge monitor pops and compares every accepted write.
module tb_vga_rect_fill;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x0;
    logic [6:0] cmd_y0;
    logic [8:0] cmd_w;
    logic [7:0] cmd_h;
    logic [2:0] cmd_color;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       plot_ready;
    logic       busy;
    logic       done;

    vga_rect_fill dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x0     (cmd_x0),
        .cmd_y0     (cmd_y0),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_color  (cmd_color),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .plot_ready (plot_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x0; int y0; int w; int h; int col;
        int ew; int eh;          // hand-clipped extent
    } vec_t;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int first_plot_cyc = -1;
    logic [17:0] exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every accepted write must match the head of the scoreboard.
    always @(negedge clock) begin
        logic [17:0] e;
        if (!reset && plot && plot_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_plot: got (%0d,%0d,c%0d) with nothing expected", x, y, colour);
            end else begin
                e = exp_q.pop_front();
                if ({x, y, colour} !== e) begin
                    n_err++;
                    $display("FAIL plot_pixel: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                             x, y, colour, e[17:10], e[9:3], e[2:0]);
                end
            end
            if (first_plot_cyc < 0) first_plot_cyc = cyc;
        end
        if (!reset && done) done_cnt++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_exp(input vec_t v);
        for (int j = 0; j < v.eh; j++)
            for (int i = 0; i < v.ew; i++)
                exp_q.push_back({8'(v.x0 + i), 7'(v.y0 + j), 3'(v.col)});
    endtask

    // Presents a command (called just after a posedge) and returns the cycle
    // number that starts right after the accepting edge; cmd_valid is left high.
    task automatic issue(input vec_t v, output int acc);
        int k;
        cmd_x0    = 8'(v.x0);
        cmd_y0    = 7'(v.y0);
        cmd_w     = 9'(v.w);
        cmd_h     = 8'(v.h);
        cmd_color = 3'(v.col);
        cmd_valid = 1'b1;
        for (k = 0; k < 40000; k++) begin
            @(negedge clock);
            if (cmd_ready) break;
        end
        if (k == 40000) begin
            $display("FAIL cmd_accept_timeout: got no cmd_ready expected cmd_ready within 40000 cycles");
            $fatal(1, "timeout");
        end
        @(posedge clock);
        #1;
        acc = cyc;
        first_plot_cyc = -1;
        push_exp(v);
    endtask

    task automatic wait_done(output int dc);
        int k;
        for (k = 0; k < 40000; k++) begin
            @(negedge clock);
            if (done) break;
        end
        if (k == 40000) begin
            $display("FAIL done_timeout: got no done expected done within 40000 cycles");
            $fatal(1, "timeout");
        end
        dc = cyc;
    endtask

    task automatic run_vec(input vec_t v);
        int acc, dc;
        issue(v, acc);
        cmd_valid = 1'b0;
        wait_done(dc);
        chk("done_cycle", dc, acc + 1 + v.ew * v.eh);
        chk("queue_empty_at_done", exp_q.size(), 0);
        if (v.ew * v.eh > 0) chk("first_plot_cycle", first_plot_cyc, acc + 1);
        @(negedge clock);
        chk("cmd_ready_after_done", int'(cmd_ready), 1);
        chk("busy_after_done", int'(busy), 0);
        @(posedge clock);
        #1;
    endtask

    vec_t vecs[7] = '{
        '{x0:3,   y0:4,   w:2,   h:2,   col:5, ew:2,  eh:2},
        '{x0:158, y0:119, w:5,   h:3,   col:3, ew:2,  eh:1},
        '{x0:10,  y0:10,  w:0,   h:4,   col:7, ew:0,  eh:0},
        '{x0:160, y0:5,   w:4,   h:4,   col:2, ew:0,  eh:0},
        '{x0:0,   y0:118, w:3,   h:9,   col:1, ew:3,  eh:2},
        '{x0:50,  y0:60,  w:4,   h:0,   col:4, ew:0,  eh:0},
        '{x0:150, y0:110, w:256, h:127, col:2, ew:10, eh:10}
    };

    initial begin
        vec_t v, v2;
        int acc, acc2, dc, dcnt0, k;

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_x0     = '0;
        cmd_y0     = '0;
        cmd_w      = '0;
        cmd_h      = '0;
        cmd_color  = '0;
        plot_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_xyc", int'({x, y, colour}), 0);
        @(posedge clock);
        #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Stall on the second pixel of a 3x1 fill.
        v = '{x0:20, y0:30, w:3, h:1, col:6, ew:3, eh:1};
        issue(v, acc);
        cmd_valid = 1'b0;
        for (k = 0; k < 10; k++) begin
            @(posedge clock);
            #1;
            if (plot && x == 8'd21) break;
        end
        chk("stall_reach_pixel2", k < 10 ? 1 : 0, 1);
        plot_ready = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("stall_hold", int'({plot, x, y, colour}), int'({1'b1, 8'd21, 7'd30, 3'd6}));
            @(posedge clock);
            #1;
        end
        plot_ready = 1'b1;
        wait_done(dc);
        chk("stall_done_cycle", dc, acc + 1 + 3 + 3);
        chk("stall_queue_empty", exp_q.size(), 0);
        @(posedge clock);
        #1;

        // Reset on the 5th plot of a 4x4 fill.
        v = '{x0:30, y0:40, w:4, h:4, col:3, ew:4, eh:4};
        issue(v, acc);
        cmd_valid = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            if (plot && x == 8'd30 && y == 7'd41) break;
        end
        chk("rst5_reach_pixel5", k < 20 ? 1 : 0, 1);
        reset = 1'b1;
        dcnt0 = done_cnt;
        @(posedge clock);
        #1;
        exp_q.delete();
        reset = 1'b0;
        @(negedge clock);
        chk("rst5_plot", int'(plot), 0);
        chk("rst5_busy", int'(busy), 0);
        chk("rst5_cmd_ready", int'(cmd_ready), 1);
        chk("rst5_xyc", int'({x, y, colour}), 0);
        repeat (3) @(negedge clock);
        chk("rst5_no_done", done_cnt, dcnt0);
        @(posedge clock);
        #1;
        run_vec('{x0:5, y0:6, w:2, h:2, col:2, ew:2, eh:2});

        // Full clear with a second command held behind it.
        v  = '{x0:0,  y0:0,  w:160, h:120, col:4, ew:160, eh:120};
        v2 = '{x0:10, y0:10, w:1,   h:1,   col:2, ew:1,   eh:1};
        dcnt0 = done_cnt;
        issue(v, acc);
        issue(v2, acc2);
        cmd_valid = 1'b0;
        chk("clear_accept_period", acc2 - acc, 19203);
        chk("clear_done_before_second", done_cnt, dcnt0 + 1);
        wait_done(dc);
        chk("second_done_cycle", dc, acc2 + 2);
        chk("clear_queue_empty", exp_q.size(), 0);
        repeat (2) @(negedge clock);
        chk("clear_done_total", done_cnt, dcnt0 + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
